// File: rtl/xbar_bypass_pkg.sv
// Shared router definitions for the HyCUBE crossbar slice: the flit type,
// the port index map and a multi-hot detect helper.
package SMARTPkg;
  localparam int FLIT_W = 33;
  typedef logic [FLIT_W-1:0] FlitFixed;

  localparam int EAST  = 0;
  localparam int SOUTH = 1;
  localparam int WEST  = 2;
  localparam int NORTH = 3;
  localparam int ALU_T = 4;
  localparam int TREG  = 5;

  localparam int NUM_INPUT_PORTS  = 6;
  localparam int NUM_OUTPUT_PORTS = 7;
  localparam int NUM_LOCAL_PORTS  = 4;

  // Clearing the lowest set bit leaves something only if two or more were set.
  function automatic logic multi_hot(input logic [NUM_INPUT_PORTS-1:0] sel);
    return (sel & (sel - NUM_INPUT_PORTS'(1))) != '0;
  endfunction
endpackage

// File: rtl/xbar_mux_onehot.sv
// Single crossbar output: AND-OR mux over all sources. A multi-hot select
// yields the OR of the chosen sources, a zero select yields zero.
module xbar_mux_onehot
  import SMARTPkg::*;
#(
  parameter int NUM_INPUTS = NUM_INPUT_PORTS,
  parameter int DATA_WIDTH = $bits(FlitFixed)
) (
  input  logic [NUM_INPUTS-1:0] sel,
  input  logic [DATA_WIDTH-1:0] data_in [NUM_INPUTS],
  output logic [DATA_WIDTH-1:0] data_out
);
  always_comb begin
    data_out = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      data_out = data_out | ({DATA_WIDTH{sel[k]}} & data_in[k]);
    end
  end
endmodule

// File: rtl/xbar_bypass.sv
// HyCUBE router output crossbar with per-direction multi-hop bypass and sticky
// multi-hot select flags. Define XBAR_OUT_REG_EN to register o__data_out.
module xbar_bypass
  import SMARTPkg::*;
#(
  parameter int DATA_WIDTH  = $bits(FlitFixed),
  parameter int NUM_INPUTS  = NUM_INPUT_PORTS,
  parameter int NUM_OUTPUTS = NUM_OUTPUT_PORTS,
  parameter int NUM_LOCAL   = NUM_LOCAL_PORTS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_INPUTS-1:0]  i__sel            [NUM_OUTPUTS],
  input  logic [DATA_WIDTH-1:0]  i__data_in_local  [NUM_LOCAL],
  input  logic [DATA_WIDTH-1:0]  i__data_in_remote [NUM_INPUTS],
  input  logic [NUM_LOCAL-1:0]   regbypass,
  output logic [DATA_WIDTH-1:0]  o__data_out       [NUM_OUTPUTS],
  output logic [NUM_OUTPUTS-1:0] o__sel_err
);
  logic [DATA_WIDTH-1:0]  src     [NUM_INPUTS];
  logic [DATA_WIDTH-1:0]  mux_out [NUM_OUTPUTS];
  logic [NUM_OUTPUTS-1:0] sel_err_q;

  // Directional sources pick raw or registered flit; ALU_T/TREG have no copy.
  always_comb begin
    for (int k = 0; k < NUM_INPUTS; k++) begin
      src[k] = i__data_in_remote[k];
    end
    for (int k = 0; k < NUM_LOCAL; k++) begin
      if (!regbypass[k]) src[k] = i__data_in_local[k];
    end
  end

  for (genvar j = 0; j < NUM_OUTPUTS; j++) begin : g_out
    xbar_mux_onehot #(
      .NUM_INPUTS (NUM_INPUTS),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_mux (
      .sel      (i__sel[j]),
      .data_in  (src),
      .data_out (mux_out[j])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sel_err_q <= '0;
    end else begin
      for (int j = 0; j < NUM_OUTPUTS; j++) begin
        sel_err_q[j] <= sel_err_q[j] | multi_hot(i__sel[j]);
      end
    end
  end

  assign o__sel_err = sel_err_q;

`ifdef XBAR_OUT_REG_EN
  logic [DATA_WIDTH-1:0] data_out_p1 [NUM_OUTPUTS];

  // p0 -> p1: mux result captured, cleared while in reset
  always_ff @(posedge clk) begin
    for (int j = 0; j < NUM_OUTPUTS; j++) begin
      if (!reset) data_out_p1[j] <= '0;
      else        data_out_p1[j] <= mux_out[j];
    end
  end

  always_comb begin
    for (int j = 0; j < NUM_OUTPUTS; j++) o__data_out[j] = data_out_p1[j];
  end
`else
  always_comb begin
    for (int j = 0; j < NUM_OUTPUTS; j++) o__data_out[j] = mux_out[j];
  end
`endif
endmodule

// File: tb/tb_xbar_bypass.sv
// Self-checking bench for xbar_bypass: directed vector table, hand-written
// sticky-flag / reset sequences, and random stimulus against a reference model.
module tb_xbar_bypass;
  localparam int DW = 33;
  localparam int NI = 6;
  localparam int NO = 7;
  localparam int NL = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [NI-1:0] sel  [NO];
  logic [DW-1:0] loc  [NL];
  logic [DW-1:0] rem  [NI];
  logic [NL-1:0] byp;
  logic [DW-1:0] dout [NO];
  logic [NO-1:0] err;

  int checks = 0;
  int errors = 0;

  logic [NO-1:0] err_m;
  logic          last_rst;

  xbar_bypass dut (
    .clk               (clk),
    .reset             (reset),
    .i__sel            (sel),
    .i__data_in_local  (loc),
    .i__data_in_remote (rem),
    .regbypass         (byp),
    .o__data_out       (dout),
    .o__sel_err        (err)
  );

  always #5 clk = ~clk;

`ifdef XBAR_OUT_REG_EN
  localparam bit REG_OUT = 1'b1;
`else
  localparam bit REG_OUT = 1'b0;
`endif

  typedef struct {
    logic [NL-1:0] byp;
    int            oidx;
    logic [NI-1:0] sel;
    logic [DW-1:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Source k as the router sees it, straight from the bypass rule.
  function automatic logic [DW-1:0] eff_src(input int k);
    if (k < NL && byp[k] == 1'b0) return loc[k];
    return rem[k];
  endfunction

  function automatic logic [DW-1:0] ref_out(input int j);
    logic [DW-1:0] acc = '0;
    for (int k = 0; k < NI; k++) begin
      if (sel[j][k]) acc = acc | eff_src(k);
    end
    return acc;
  endfunction

  task automatic step();
    @(posedge clk);
    for (int j = 0; j < NO; j++) begin
      if (!reset) err_m[j] = 1'b0;
      else if ($countones(sel[j]) > 1) err_m[j] = 1'b1;
    end
    last_rst = reset;
    #1;
  endtask

  task automatic chk_all(input string tag);
    for (int j = 0; j < NO; j++) begin
      logic [DW-1:0] e;
      e = (REG_OUT && !last_rst) ? '0 : ref_out(j);
      chk($sformatf("%s_out%0d", tag, j), dout[j], e);
    end
    chk($sformatf("%s_err", tag), DW'(err), DW'(err_m));
  endtask

  task automatic clear_sel();
    for (int j = 0; j < NO; j++) sel[j] = '0;
  endtask

  vec_t vecs [7];

  initial begin
    reset = 1'b0;
    byp   = '0;
    err_m = '0;
    last_rst = 1'b0;
    clear_sel();
    for (int k = 0; k < NL; k++) loc[k] = '0;
    for (int k = 0; k < NI; k++) rem[k] = '0;

    step();
    step();
    chk("reset_err", DW'(err), '0);
    for (int j = 0; j < NO; j++) chk($sformatf("reset_out%0d", j), dout[j], '0);

    // Directed vectors
    reset  = 1'b1;
    rem[0] = 33'h1_0000_00AA;
    loc[0] = 33'h0_0000_0055;
    rem[3] = 33'h0_0000_00FF;
    loc[3] = 33'h0_0000_0777;
    rem[4] = 33'h123;
    rem[5] = 33'h456;
    vecs[0] = '{4'b0001, 2, 6'b000001, 33'h1_0000_00AA};
    vecs[1] = '{4'b0000, 2, 6'b000001, 33'h0_0000_0055};
    vecs[2] = '{4'b0000, 4, 6'b010000, 33'h123};
    vecs[3] = '{4'b0000, 5, 6'b100000, 33'h456};
    vecs[4] = '{4'b1000, 6, 6'b001000, 33'h0FF};
    vecs[5] = '{4'b0000, 6, 6'b001000, 33'h777};
    vecs[6] = '{4'b1111, 0, 6'b000000, 33'h0};
    for (int v = 0; v < 7; v++) begin
      clear_sel();
      byp = vecs[v].byp;
      sel[vecs[v].oidx] = vecs[v].sel;
      step();
      chk($sformatf("vec%0d", v), dout[vecs[v].oidx], vecs[v].exp);
    end

    // Broadcast of N to every output, then all-zero selects
    byp = 4'b1000;
    for (int j = 0; j < NO; j++) sel[j] = 6'b001000;
    step();
    for (int j = 0; j < NO; j++) chk($sformatf("bcast_out%0d", j), dout[j], 33'h0FF);
    clear_sel();
    step();
    for (int j = 0; j < NO; j++) chk($sformatf("zero_out%0d", j), dout[j], 33'h0);
    chk("bcast_err", DW'(err), '0);

    // Multi-hot OR and sticky flag
    rem[0] = 33'h0F0;
    rem[1] = 33'h00F;
    byp    = 4'b0011;
    sel[1] = 6'b000011;
    step();
    chk("mhot_out1", dout[1], 33'h0FF);
    chk("mhot_err_set", DW'(err), DW'(7'b0000010));
    sel[1] = 6'b000001;
    step();
    chk("mhot_err_hold", DW'(err), DW'(7'b0000010));
    chk("mhot_onehot_out1", dout[1], 33'h0F0);
    reset = 1'b0;
    step();
    chk("mhot_err_clear", DW'(err), '0);

    // Reset wins over a simultaneous multi-hot select
    sel[3] = 6'b000110;
    step();
    chk("rst_prio_err", DW'(err), '0);
    reset = 1'b1;
    clear_sel();
    step();
    chk("rst_prio_err_after", DW'(err), '0);

    // Select change latency on output 0: E -> W
    rem[0] = 33'h1_AAAA_0001;
    rem[2] = 33'h0_BBBB_0002;
    byp    = 4'b0101;
    sel[0] = 6'b000001;
    step();
    chk("lat_E", dout[0], 33'h1_AAAA_0001);
    sel[0] = 6'b000100;
    #1;
    if (REG_OUT) chk("lat_W_before_edge", dout[0], 33'h1_AAAA_0001);
    else         chk("lat_W_comb", dout[0], 33'h0_BBBB_0002);
    step();
    chk("lat_W_after_edge", dout[0], 33'h0_BBBB_0002);

    // Mid-stream reset pulse
    reset = 1'b0;
    step();
    for (int j = 0; j < NO; j++)
      chk($sformatf("midrst_out%0d", j), dout[j], REG_OUT ? 33'h0 : ref_out(j));
    reset = 1'b1;
    #1;
    chk("midrst_held_out0", dout[0], REG_OUT ? 33'h0 : 33'h0_BBBB_0002);
    step();
    chk("midrst_resume_out0", dout[0], 33'h0_BBBB_0002);

    // Random stimulus against the reference model
    for (int it = 0; it < 300; it++) begin
      for (int k = 0; k < NI; k++) rem[k] = {1'($urandom), $urandom};
      for (int k = 0; k < NL; k++) loc[k] = {1'($urandom), $urandom};
      byp = 4'($urandom);
      for (int j = 0; j < NO; j++) begin
        case ($urandom_range(0, 9))
          0:       sel[j] = '0;
          1:       sel[j] = 6'($urandom);
          default: sel[j] = 6'(1) << $urandom_range(0, 5);
        endcase
      end
      reset = ($urandom_range(0, 15) != 0);
      step();
      chk_all($sformatf("rnd%0d", it));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/xbar_bypass.md
Name: xbar_bypass

Overview:
- Output-select crossbar inside the HyCUBE router.
- Each of 7 output ports (E, S, W, N, plus three toward ALU operands/treg) picks one of 6 input sources (E, S, W, N, ALU_T, TREG) under a per-output one-hot select.
- For the four neighbour directions, a per-direction bypass bit chooses between the raw incoming flit (single-cycle multi-hop bypass) and the router's registered copy of that flit.
- A sticky select-error flag supports verification.

Parameters:
- DATA_WIDTH, 33, flit width in bits (width of FlitFixed).
- NUM_INPUTS, 6, crossbar input sources; fixed value.
- NUM_OUTPUTS, 7, crossbar output ports; fixed value.
- NUM_LOCAL, 4, directional inputs that have a registered copy (indices 0..3); fixed value.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous reset, active-low: state clears on the rising clk edge while reset==0.
- i__sel  input  [NUM_INPUTS-1:0] x NUM_OUTPUTS (unpacked)  one-hot source select per output; bit k selects input k.
- i__data_in_local  input  [DATA_WIDTH-1:0] x NUM_LOCAL  registered copies of directional inputs 0..3.
- i__data_in_remote  input  [DATA_WIDTH-1:0] x NUM_INPUTS  raw inputs. Index 0=E, 1=S, 2=W, 3=N, 4=ALU_T, 5=TREG.
- regbypass  input  [NUM_LOCAL-1:0]  per-direction bypass: 1 = use remote (raw); 0 = use local (registered).
- o__data_out  output  [DATA_WIDTH-1:0] x NUM_OUTPUTS  crossbar outputs.
- o__sel_err  output  [NUM_OUTPUTS-1:0]  sticky flag per output: a multi-hot select was seen.

Behaviour:
- Effective source k, for k in 0..3: regbypass[k] ? i__data_in_remote[k] : i__data_in_local[k].
- Effective source 4, 5: always i__data_in_remote[4], i__data_in_remote[5]; there is no local copy.
- o__data_out[j] = bitwise OR over k of (i__sel[j][k] ? src[k] : 0).
  - One-hot select: passes the selected source unchanged.
  - All-zero select: output is 0.
  - Multi-hot select: output is the OR of the selected sources. This is legal but flagged.
- Data path is purely combinational, zero latency, no handshake. Any output may select any input, including the same input on several outputs (broadcast).
- Changing regbypass or a select takes effect in the same cycle.
- o__sel_err[j]:
  - Set on a clk rising edge when reset==1 and popcount(i__sel[j]) > 1.
  - Holds once set.
  - Cleared to 0 on a clk edge with reset==0; reset has priority over a simultaneous set.
  - Reset value is all zeros.
- The data path does not depend on reset: o__data_out is valid during reset.

Optional Feature:
- Macro XBAR_OUT_REG_EN.
- Defined:
  - o__data_out is registered on the clk rising edge, giving 1-cycle latency from select, bypass and data inputs.
  - Synchronous active-low reset clears every o__data_out word to 0.
  - A reset asserted mid-stream zeroes the outputs on the next edge.
  - The first valid data appears on the edge after reset is released.
- Undefined: combinational outputs as specified above.
- o__sel_err behaves identically in both builds.

Decomposition:
- Shared package (SMARTPkg):
  - FlitFixed typedef (33 bits).
  - Port index constants EAST=0, SOUTH=1, WEST=2, NORTH=3, ALU_T=4, TREG=5.
  - NUM_INPUT_PORTS=6, NUM_OUTPUT_PORTS=7.
- One natural sub-module: xbar_mux_onehot, a single-output AND-OR one-hot mux of NUM_INPUTS x DATA_WIDTH, instantiated NUM_OUTPUTS times.
- The bypass 2:1 selection and the error flags live in the top level.

Test Plan:
- Bypass select: remote[0]=0x1_0000_00AA, local[0]=0x0_0000_0055, i__sel[2]=6'b000001.
  - regbypass=4'b0001 -> out[2]=0x1_0000_00AA.
  - regbypass=4'b0000 -> out[2]=0x0_0000_0055.
- ALU/TREG ignore bypass: remote[4]=0x123, remote[5]=0x456, i__sel[4]=6'b010000, i__sel[5]=6'b100000, regbypass=4'b0000 -> out[4]=0x123, out[5]=0x456.
- Broadcast: all 7 selects = 6'b001000 (N), regbypass[3]=1, remote[3]=0x0FF -> every output = 0x0FF. With zero select everywhere -> every output = 0.
- Multi-hot select: i__sel[1]=6'b000011, src0=0x0F0, src1=0x00F (bypass on) -> out[1]=0x0FF.
  - o__sel_err[1]=1 after the next edge and stays set after the select returns to one-hot.
  - o__sel_err clears on an edge with reset=0.
- Reset priority: reset=0 in the same cycle as a multi-hot select -> o__sel_err stays 0.
- With XBAR_OUT_REG_EN defined:
  - Change i__sel[0] from E to W -> out[0] updates exactly one edge later.
  - reset=0 for one edge -> all outputs become 0, then resume the next edge after release.
